// File: rtl/histogram_ctrl.sv
// Histogram builder: read-modify-write initiator for a single-port bin memory,
// with full-memory clear and ordered bin dump.
module histogram_ctrl #(
  parameter int BIN_W   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic [BIN_W-1:0]   pixel_val,
  output logic               pixel_ready,
  input  logic               start_clear,
  input  logic               start_dump,
  output logic               busy,
  output logic               mem_wr_en,
  output logic [BIN_W-1:0]   mem_index,
  output logic [COUNT_W-1:0] mem_wr_val,
  input  logic [COUNT_W-1:0] mem_rd_val,
  output logic               dump_valid,
  output logic [BIN_W-1:0]   dump_bin,
  output logic [COUNT_W-1:0] dump_count
);

  localparam logic [BIN_W-1:0]   IDX_ZERO  = {BIN_W{1'b0}};
  localparam logic [BIN_W-1:0]   IDX_ONE   = BIN_W'(1);
  localparam logic [BIN_W-1:0]   IDX_LAST  = {BIN_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_CLEAR     = 3'd0,
    S_IDLE      = 3'd1,
    S_ACC_RD    = 3'd2,
    S_ACC_WR    = 3'd3,
    S_DUMP      = 3'd4,
    S_DUMP_TAIL = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [BIN_W-1:0]   idx_r, idx_s;
  logic [BIN_W-1:0]   pix_r, pix_s;
  logic               dump_valid_r;
  logic [BIN_W-1:0]   dump_bin_r;
  logic [COUNT_W-1:0] count_hold_r;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = CNT_MAX;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // State, sweep index, latched pixel and dump output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_CLEAR;
      idx_r        <= IDX_ZERO;
      pix_r        <= IDX_ZERO;
      dump_valid_r <= 1'b0;
      dump_bin_r   <= IDX_ZERO;
      count_hold_r <= CNT_ZERO;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      pix_r        <= pix_s;
      // read issued in DUMP returns data next cycle, so the bin tag lags by one
      dump_valid_r <= (state_r == S_DUMP);
      if (state_r == S_DUMP) begin
        dump_bin_r <= idx_r;
      end
      if (dump_valid_r) begin
        count_hold_r <= mem_rd_val;
      end
    end
  end

  // Next-state and sweep index; commands outrank pixels in IDLE
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    pix_s   = pix_r;
    case (state_r)
      S_CLEAR: begin
        idx_s = idx_r + IDX_ONE;
        if (idx_r == IDX_LAST) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_CLEAR;
        end
      end
      S_IDLE: begin
        if (start_clear) begin
          state_s = S_CLEAR;
          idx_s   = IDX_ZERO;
        end else if (start_dump) begin
          state_s = S_DUMP;
          idx_s   = IDX_ZERO;
        end else if (pixel_valid) begin
          state_s = S_ACC_RD;
          pix_s   = pixel_val;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACC_RD:    state_s = S_ACC_WR;
      S_ACC_WR:    state_s = S_IDLE;
      S_DUMP: begin
        idx_s = idx_r + IDX_ONE;
        if (idx_r == IDX_LAST) begin
          state_s = S_DUMP_TAIL;
        end else begin
          state_s = S_DUMP;
        end
      end
      S_DUMP_TAIL: state_s = S_IDLE;
      default: begin
        state_s = S_CLEAR;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Memory port and handshake decode from the current state
  always_comb begin
    pixel_ready = 1'b0;
    busy        = 1'b1;
    mem_wr_en   = 1'b0;
    mem_index   = idx_r;
    mem_wr_val  = CNT_ZERO;
    case (state_r)
      S_CLEAR: begin
        mem_wr_en = 1'b1;
      end
      S_IDLE: begin
        pixel_ready = 1'b1;
        busy        = 1'b0;
      end
      S_ACC_RD: begin
        mem_index = pix_r;
      end
      S_ACC_WR: begin
        mem_wr_en  = 1'b1;
        mem_index  = pix_r;
        mem_wr_val = sat_inc(mem_rd_val);
      end
      S_DUMP:      mem_index = idx_r;
      S_DUMP_TAIL: mem_index = idx_r;
      default: begin
        mem_wr_en = 1'b0;
      end
    endcase
  end

  // Read data is only valid in the cycle after the read; hold it afterwards
  always_comb begin
    dump_valid = dump_valid_r;
    dump_bin   = dump_bin_r;
    if (dump_valid_r) begin
      dump_count = mem_rd_val;
    end else begin
      dump_count = count_hold_r;
    end
  end

endmodule

// File: tb/tb_histogram_ctrl.sv
// Self-checking bench for histogram_ctrl: behavioural bin memory plus a
// reference histogram kept as a plain array of saturating counts.
module tb_histogram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_valid;
  logic [7:0]  pixel_val;
  logic        pixel_ready;
  logic        start_clear;
  logic        start_dump;
  logic        busy;
  logic        mem_wr_en;
  logic [7:0]  mem_index;
  logic [15:0] mem_wr_val;
  logic [15:0] mem_rd_val;
  logic        dump_valid;
  logic [7:0]  dump_bin;
  logic [15:0] dump_count;

  logic        preload_en;
  logic [7:0]  preload_idx;
  logic [15:0] preload_val;
  logic [15:0] mem [0:255];

  int checks = 0;
  int errors = 0;
  int ref_hist [0:255];

  histogram_ctrl #(.BIN_W(8), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .pixel_valid(pixel_valid), .pixel_val(pixel_val), .pixel_ready(pixel_ready),
    .start_clear(start_clear), .start_dump(start_dump), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_index(mem_index), .mem_wr_val(mem_wr_val),
    .mem_rd_val(mem_rd_val),
    .dump_valid(dump_valid), .dump_bin(dump_bin), .dump_count(dump_count)
  );

  always #5 clk = ~clk;

  // Single-port memory: write when enabled, otherwise registered read
  always @(posedge clk) begin
    if (preload_en) begin
      mem[preload_idx] <= preload_val;
    end else if (mem_wr_en) begin
      mem[mem_index] <= mem_wr_val;
    end else begin
      mem_rd_val <= mem[mem_index];
    end
  end

  task automatic check_value(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has just entered CLEAR at index 0
  task automatic expect_clear();
    check_value("clear_busy", busy, 1);
    check_value("clear_ready", pixel_ready, 0);
    for (int i = 0; i < 256; i++) begin
      check_value($sformatf("clear_wr_en_%0d", i), mem_wr_en, 1);
      check_value($sformatf("clear_idx_%0d", i), mem_index, i);
      check_value($sformatf("clear_val_%0d", i), mem_wr_val, 0);
      check_value($sformatf("clear_no_dump_%0d", i), dump_valid, 0);
      step();
    end
    for (int b = 0; b < 256; b++) ref_hist[b] = 0;
    check_value("idle_busy", busy, 0);
    check_value("idle_ready", pixel_ready, 1);
  endtask

  task automatic send_pixel(input logic [7:0] v);
    int n;
    int exp_cnt;
    n = 0;
    pixel_val   = v;
    pixel_valid = 1'b1;
    while (!pixel_ready && n < 50) begin
      step();
      n++;
    end
    check_value("px_accept_bound", (n < 50) ? 1 : 0, 1);
    step();
    pixel_valid = 1'b0;
    pixel_val   = 8'($urandom_range(0, 255));
    check_value("acc_rd_ready", pixel_ready, 0);
    check_value("acc_rd_wr_en", mem_wr_en, 0);
    check_value("acc_rd_idx", mem_index, v);
    step();
    exp_cnt = (ref_hist[v] + 1 > 65535) ? 65535 : ref_hist[v] + 1;
    check_value("acc_wr_ready", pixel_ready, 0);
    check_value("acc_wr_wr_en", mem_wr_en, 1);
    check_value("acc_wr_idx", mem_index, v);
    check_value("acc_wr_val", mem_wr_val, exp_cnt);
    ref_hist[v] = exp_cnt;
    step();
    check_value("acc_back_ready", pixel_ready, 1);
  endtask

  task automatic run_dump();
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    check_value("dump_busy", busy, 1);
    check_value("dump_first_valid", dump_valid, 0);
    check_value("dump_rd", mem_wr_en, 0);
    check_value("dump_first_idx", mem_index, 0);
    step();
    for (int i = 0; i < 256; i++) begin
      check_value($sformatf("dump_valid_%0d", i), dump_valid, 1);
      check_value($sformatf("dump_bin_%0d", i), dump_bin, i);
      check_value($sformatf("dump_count_%0d", i), dump_count, ref_hist[i]);
      step();
    end
    check_value("dump_end_valid", dump_valid, 0);
    check_value("dump_end_busy", busy, 0);
    check_value("dump_hold_bin", dump_bin, 255);
    check_value("dump_hold_count", dump_count, ref_hist[255]);
  endtask

  initial begin
    int n;
    reset = 1'b1; pixel_valid = 1'b0; pixel_val = 8'd0;
    start_clear = 1'b0; start_dump = 1'b0;
    preload_en = 1'b0; preload_idx = 8'd0; preload_val = 16'd0;

    // Reset and power-on clear sweep
    step();
    reset = 1'b0;
    check_value("rst_dump_valid", dump_valid, 0);
    check_value("rst_dump_bin", dump_bin, 0);
    check_value("rst_dump_count", dump_count, 0);
    expect_clear();

    // Single pixel timing, then the 5,5,200 pattern and a dump
    send_pixel(8'd7);
    send_pixel(8'd5);
    send_pixel(8'd5);
    send_pixel(8'd200);
    run_dump();

    // Randomized stream with clustered values so bins repeat
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) send_pixel(8'($urandom_range(0, 255)));
      else send_pixel(8'($urandom_range(10, 13)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
    run_dump();

    // Saturation at the top of the count range
    preload_en = 1'b1; preload_idx = 8'd9; preload_val = 16'hFFFE;
    step();
    preload_en = 1'b0;
    ref_hist[9] = 32'hFFFE;
    for (int k = 0; k < 3; k++) send_pixel(8'd9);
    run_dump();

    // Simultaneous clear, dump and pixel: clear wins
    send_pixel(8'd3);
    start_clear = 1'b1; start_dump = 1'b1; pixel_valid = 1'b1; pixel_val = 8'd3;
    step();
    start_clear = 1'b0; start_dump = 1'b0; pixel_valid = 1'b0;
    expect_clear();
    run_dump();

    // Reset in the middle of a dump
    send_pixel(8'd42);
    start_dump = 1'b1;
    step();
    start_dump = 1'b0;
    n = 0;
    while (!(dump_valid && dump_bin == 8'd100) && n < 400) begin
      step();
      n++;
    end
    check_value("reach_bin100", (n < 400) ? 1 : 0, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_value("abort_dump_valid", dump_valid, 0);
    check_value("abort_dump_bin", dump_bin, 0);
    check_value("abort_dump_count", dump_count, 0);
    expect_clear();
    run_dump();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
